// File: rtl/vx_weighted_fair_arbiter_pkg.sv
// Shared helpers and default sizing for the weighted fair arbiter.
package vx_weighted_fair_arbiter_pkg;

   localparam int unsigned DEF_NUM_REQS     = 4;
   localparam int unsigned DEF_WEIGHT_WIDTH = 4;

   // Index width that stays at least one bit wide for a single requester.
   function automatic int unsigned log2up(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_weighted_fair_arbiter_prio.sv
// Fixed-priority picker: selects the lowest set bit of the request vector.
module vx_weighted_fair_arbiter_prio
   import vx_weighted_fair_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQS     = DEF_NUM_REQS,
   parameter int unsigned LOG_NUM_REQS = log2up(NUM_REQS)
) (
   input  logic [NUM_REQS-1:0]     requests,
   output logic [LOG_NUM_REQS-1:0] index_c,
   output logic [NUM_REQS-1:0]     onehot_c
);

   logic found;

   always_comb begin
      index_c = '0;
      found   = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (requests[i] && !found) begin
            found   = 1'b1;
            index_c = LOG_NUM_REQS'(i);
         end
      end
   end

   // Isolate the lowest set bit.
   assign onehot_c = requests & ~(requests - NUM_REQS'(1));

endmodule

// File: rtl/vx_weighted_fair_arbiter.sv
// Round-based fair arbiter where each requester may keep the grant for
// weight+1 consecutive accepted grants before the round moves on.
module vx_weighted_fair_arbiter
   import vx_weighted_fair_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQS     = DEF_NUM_REQS,
   parameter int unsigned WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
   parameter bit          LOCK_ENABLE  = 1'b0,
   parameter int unsigned LOG_NUM_REQS = log2up(NUM_REQS)
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             unlock,
   input  logic [NUM_REQS-1:0]              requests,
   input  logic [NUM_REQS*WEIGHT_WIDTH-1:0] weights,
   output logic [LOG_NUM_REQS-1:0]          grant_index,
   output logic [NUM_REQS-1:0]              grant_onehot,
   output logic                             grant_valid,
   output logic                             grant_last
);

   logic [NUM_REQS-1:0]     round_mask;
   logic                    owner_valid;
   logic [LOG_NUM_REQS-1:0] owner_idx;
   logic [WEIGHT_WIDTH-1:0] remain;

   logic [WEIGHT_WIDTH-1:0] weight_arr [NUM_REQS];
   logic [NUM_REQS-1:0]     active;
   logic [NUM_REQS-1:0]     base;
   logic [LOG_NUM_REQS-1:0] prio_idx;
   logic [NUM_REQS-1:0]     prio_oh;
   logic                    owner_hit;
   logic                    adv;

   always_comb begin
      for (int i = 0; i < NUM_REQS; i++) begin
         weight_arr[i] = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
   end

   // A new round begins whenever nobody left in the current round is asking.
   assign active      = round_mask & requests;
   assign base        = (|active) ? active : requests;
   assign owner_hit   = owner_valid && requests[owner_idx];
   assign adv         = (LOCK_ENABLE == 1'b0) || unlock;
   assign grant_valid = |requests;

   vx_weighted_fair_arbiter_prio #(
      .NUM_REQS     (NUM_REQS),
      .LOG_NUM_REQS (LOG_NUM_REQS)
   ) u_prio (
      .requests (base),
      .index_c  (prio_idx),
      .onehot_c (prio_oh)
   );

   // Burst owner overrides the round picker while it keeps requesting.
   always_comb begin
      grant_index  = prio_idx;
      grant_onehot = prio_oh;
      grant_last   = 1'b0;
      if (owner_hit) begin
         grant_index  = owner_idx;
         grant_onehot = NUM_REQS'(1) << owner_idx;
         grant_last   = (remain == WEIGHT_WIDTH'(1));
      end else if (grant_valid) begin
         grant_last   = (weight_arr[prio_idx] == '0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         round_mask  <= '0;
         owner_valid <= 1'b0;
         owner_idx   <= '0;
         remain      <= '0;
      end else if (adv) begin
         round_mask <= base & ~grant_onehot;
         if (owner_hit) begin
            remain      <= remain - WEIGHT_WIDTH'(1);
            owner_valid <= !grant_last;
         end else if (grant_valid) begin
            // Weight is latched only when a burst starts.
            owner_valid <= !grant_last;
            owner_idx   <= prio_idx;
            remain      <= weight_arr[prio_idx];
         end else begin
            owner_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vx_weighted_fair_arbiter.sv
// Directed and randomized checks of the weighted fair arbiter against a
// round/quota reference model, with one free-running and one locked instance.
module tb_vx_weighted_fair_arbiter;

   localparam int unsigned N = 4;
   localparam int unsigned W = 4;
   localparam int unsigned L = 2;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] wts;
   logic [L-1:0]   g_idx;
   logic [N-1:0]   g_oh;
   logic           g_valid, g_last;

   logic           unlock;
   logic [N-1:0]   l_req;
   logic [N*W-1:0] l_wts;
   logic [L-1:0]   l_idx;
   logic [N-1:0]   l_oh;
   logic           l_valid, l_last;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   vx_weighted_fair_arbiter #(.NUM_REQS(N), .WEIGHT_WIDTH(W), .LOCK_ENABLE(1'b0)) u_dut (
      .clk(clk), .reset_n(reset_n), .unlock(1'b0), .requests(req), .weights(wts),
      .grant_index(g_idx), .grant_onehot(g_oh), .grant_valid(g_valid), .grant_last(g_last));

   vx_weighted_fair_arbiter #(.NUM_REQS(N), .WEIGHT_WIDTH(W), .LOCK_ENABLE(1'b1)) u_lck (
      .clk(clk), .reset_n(reset_n), .unlock(unlock), .requests(l_req), .weights(l_wts),
      .grant_index(l_idx), .grant_onehot(l_oh), .grant_valid(l_valid), .grant_last(l_last));

   // Reference: who is still owed a burst this round, and the current burst owner.
   bit owed      [2][N];
   bit burst_on  [2];
   int burst_who [2];
   int left      [2];

   function automatic int weight_of(input logic [N*W-1:0] w, input int i);
      return int'(w[i*W +: W]);
   endfunction

   function automatic void model_reset();
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < N; i++) owed[u][i] = 1'b0;
         burst_on[u] = 1'b0; burst_who[u] = 0; left[u] = 0;
      end
   endfunction

   function automatic bit anyone_owed(input int u, input logic [N-1:0] r);
      for (int i = 0; i < N; i++) if (r[i] && owed[u][i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void model_grant(input int u, input logic [N-1:0] r, input logic [N*W-1:0] w,
                                       output int gi, output bit gv, output bit gl);
      bit still;
      gv = |r; gi = 0; gl = 1'b0;
      if (burst_on[u] && r[burst_who[u]]) begin
         gi = burst_who[u];
         gl = (left[u] == 1);
         return;
      end
      still = anyone_owed(u, r);
      for (int i = 0; i < N; i++) begin
         if (r[i] && (owed[u][i] || !still)) begin
            gi = i;
            break;
         end
      end
      if (gv) gl = (weight_of(w, gi) == 0);
   endfunction

   function automatic void model_step(input int u, input logic [N-1:0] r, input logic [N*W-1:0] w,
                                      input bit adv);
      int gi; bit gv, gl, cont, still;
      if (!adv) return;
      model_grant(u, r, w, gi, gv, gl);
      cont  = burst_on[u] && r[burst_who[u]];
      still = anyone_owed(u, r);
      for (int i = 0; i < N; i++)
         owed[u][i] = r[i] && (still ? owed[u][i] : 1'b1) && !(gv && i == gi);
      if (cont) begin
         left[u] = left[u] - 1;
         burst_on[u] = !gl;
      end else if (gv) begin
         burst_on[u] = !gl; burst_who[u] = gi; left[u] = weight_of(w, gi);
      end else begin
         burst_on[u] = 1'b0;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_unit(input int u, input string tag);
      int gi; bit gv, gl;
      logic [31:0] oi, oo, ov, ol;
      if (u == 0) begin
         model_grant(0, req, wts, gi, gv, gl);
         oi = 32'(g_idx); oo = 32'(g_oh); ov = 32'(g_valid); ol = 32'(g_last);
      end else begin
         model_grant(1, l_req, l_wts, gi, gv, gl);
         oi = 32'(l_idx); oo = 32'(l_oh); ov = 32'(l_valid); ol = 32'(l_last);
      end
      chk({tag, "_idx"},    oi, 32'(gi));
      chk({tag, "_onehot"}, oo, gv ? (32'd1 << gi) : 32'd0);
      chk({tag, "_valid"},  ov, 32'(gv));
      chk({tag, "_last"},   ol, 32'(gl));
   endtask

   // Check both instances against the model, then advance one clock.
   task automatic cycle(input string tag);
      #1;
      check_unit(0, {tag, "_u0"});
      check_unit(1, {tag, "_u1"});
      model_step(0, req, wts, 1'b1);
      model_step(1, l_req, l_wts, unlock);
      @(posedge clk);
      #1;
   endtask

   int exp2_idx  [9] = '{0, 0, 0, 1, 3, 3, 3, 3, 0};
   bit exp2_last [9] = '{0, 0, 1, 1, 0, 0, 0, 1, 0};
   int exp3_idx  [4] = '{0, 0, 1, 0};
   logic [N-1:0] req3 [4] = '{4'b0011, 4'b0011, 4'b0010, 4'b0011};

   initial begin
      reset_n = 1'b0; req = '0; wts = '0; unlock = 1'b0; l_req = '0; l_wts = '0;
      model_reset();
      #1;
      chk("rst_idx",    32'(g_idx),   32'd0);
      chk("rst_onehot", 32'(g_oh),    32'd0);
      chk("rst_valid",  32'(g_valid), 32'd0);
      chk("rst_last",   32'(g_last),  32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      // All weights zero: plain round robin, every grant is the last.
      req = 4'b1111; wts = '0;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("rr_idx",  32'(g_idx),  32'(k % 4));
         chk("rr_last", 32'(g_last), 32'd1);
         cycle("rr");
      end

      // Weighted bursts {3,0,0,2} with requests 1011.
      req = 4'b1011; wts = {4'd3, 4'd0, 4'd0, 4'd2};
      for (int k = 0; k < 9; k++) begin
         #1;
         chk("wt_idx",  32'(g_idx),  32'(exp2_idx[k]));
         chk("wt_last", 32'(g_last), 32'(exp2_last[k]));
         cycle("wt");
      end

      // No requests after a burst.
      req = '0;
      #1;
      chk("idle_idx",    32'(g_idx),   32'd0);
      chk("idle_onehot", 32'(g_oh),    32'd0);
      chk("idle_valid",  32'(g_valid), 32'd0);
      cycle("idle");

      // Owner drops its request and forfeits the rest of its quota.
      wts = {4'd0, 4'd0, 4'd0, 4'd5};
      for (int k = 0; k < 4; k++) begin
         req = req3[k];
         #1;
         chk("forfeit_idx", 32'(g_idx), 32'(exp3_idx[k]));
         cycle("forfeit");
      end
      req = '0;
      cycle("idle2");

      // Locked instance holds its state until unlock.
      l_req = 4'b0110; l_wts = '0; unlock = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("lock_hold_idx", 32'(l_idx), 32'd1);
         cycle("lock_hold");
      end
      unlock = 1'b1;
      cycle("lock_pulse");
      unlock = 1'b0;
      #1;
      chk("lock_moved_idx", 32'(l_idx), 32'd2);
      cycle("lock_after");
      l_req = '0;
      cycle("lock_idle");

      // Async reset in the middle of req2's burst.
      wts = {4'd0, 4'd3, 4'd0, 4'd0}; req = 4'b0100;
      cycle("burst_a");
      cycle("burst_b");
      req = 4'b0110;
      #1;
      chk("burst_cont_idx", 32'(g_idx), 32'd2);
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_mid_idx",  32'(g_idx),  32'd1);
      chk("rst_mid_last", 32'(g_last), 32'd1);
      @(negedge clk) reset_n = 1'b1;
      #1;
      chk("rst_rel_idx", 32'(g_idx), 32'd1);
      cycle("rst_rel");

      // Randomized traffic with weights changing under running bursts.
      for (int k = 0; k < 400; k++) begin
         req   = N'($urandom);
         l_req = N'($urandom);
         if ($urandom_range(0, 7) == 0) req = '0;
         for (int i = 0; i < N; i++) begin
            wts[i*W +: W]   = ($urandom_range(0, 7) == 0) ? 4'd15 : W'($urandom_range(0, 3));
            l_wts[i*W +: W] = W'($urandom_range(0, 3));
         end
         unlock = 1'($urandom_range(0, 1));
         cycle("rnd");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
